// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction adds the nines complement of B with an inverted borrow as carry-in.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_r, b_r, res_r, res_next;
    logic            sub_r, c_r, c_next, err_acc, err_next;
    logic [IW-1:0]   idx;
    logic [3:0]      a_d, b_d, bd, dig;
    logic [4:0]      t;
    logic            last;

    assign last = (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-digit BCD add with decimal correction; invalid digits pass through unsaturated.
    always_comb begin
        a_d      = a_r[idx*4 +: 4];
        b_d      = b_r[idx*4 +: 4];
        bd       = sub_r ? (4'd9 - b_d) : b_d;
        t        = {1'b0, a_d} + {1'b0, bd} + {4'b0000, c_r};
        if (t > 5'd9) begin
            dig    = t[3:0] + 4'd6;
            c_next = 1'b1;
        end else begin
            dig    = t[3:0];
            c_next = 1'b0;
        end
        err_next = err_acc | (a_d > 4'd9) | (b_d > 4'd9);
        res_next = res_r;
        res_next[idx*4 +: 4] = dig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            sub_r   <= 1'b0;
            c_r     <= 1'b0;
            err_acc <= 1'b0;
            idx     <= '0;
            s       <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            c_r     <= sub ? ~cin : cin;
            err_acc <= 1'b0;
            idx     <= '0;
        end else if (state == RUN) begin
            res_r   <= res_next;
            c_r     <= c_next;
            err_acc <= err_next;
            idx     <= last ? '0 : idx + 1'b1;
            if (last) begin
                s    <= res_next;
                cout <= c_next;
                err  <= err_next;
            end
        end
    end

endmodule
